spi_master_shifter: RTL and testbench
=====================================

# spi_master_shifter

Mode-0 SPI shift engine that consumes the SCK produced by the SPI clock divider and runs the serial transaction for one word. It sits between the CPU-facing SPI register interface and the divider. It accepts a parallel word on a start strobe and asserts chip select. It enables the divider, shifts the word out on MOSI while capturing MISO on SCK edges, then returns the received word with a one-cycle done pulse. All logic runs on clk_cpu; SCK is treated as a same-domain registered signal and is edge-detected, never used as a clock.

## Interface
- DATA_W, 8, word length in bits (≥2)
- clk_cpu  input  1  CPU clock; also clocks the divider
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a transfer; sampled only in IDLE
- tx_data  input  DATA_W  word to transmit; latched on accepted start
- sck_in  input  1  SCK from divider output (idles 0 while divider disabled)
- miso  input  1  serial data from slave
- div_en  output  1  enable to divider `en`
- cs_n  output  1  active-low chip select
- mosi  output  1  serial data to slave
- rx_data  output  DATA_W  last received word; updated only at completion
- busy  output  1  transfer in progress
- done  output  1  one-cycle completion pulse

## Operation
- Reset values: div_en=0, cs_n=1, mosi=0, rx_data=0, busy=0, done=0, state=IDLE, bit_cnt=0, sck_q=0.
- sck_q is sck_in registered each cycle. rise = sck_in & ~sck_q. fall = ~sck_in & sck_q.
- IDLE: div_en=0, cs_n=1, busy=0.
  - On start=1: tx_shift←tx_data, rx_shift←0, bit_cnt←0, cs_n←0, div_en←1, busy←1, mosi←first bit (tx_data[DATA_W-1]), →XFER.
- XFER:
  - On rise: rx_shift←{rx_shift[DATA_W-2:0], miso}, bit_cnt←bit_cnt+1.
  - On fall with bit_cnt<DATA_W: tx_shift shifts one position, mosi←next bit.
  - On fall with bit_cnt==DATA_W: div_en←0, cs_n←1, busy←0, rx_data←rx_shift, done←1, mosi←0, →IDLE.
- rise and fall are mutually exclusive by construction. A rise/fall in IDLE is ignored.
- bit_cnt width is clog2(DATA_W+1). It never wraps within a transfer.
- done is forced 0 in every cycle other than the completion cycle.
- start while busy=1 is ignored; no queuing.
- start in the cycle done=1 (state already IDLE) is accepted. Back-to-back words then have cs_n high for exactly one clk_cpu cycle.
- Asynchronous rst mid-transfer returns all outputs to reset values immediately. rx_data is cleared and no done pulse is issued.

## Timing
- Accepted start at edge k gives cs_n=0, div_en=1, and the first mosi bit valid after edge k.
- With divider half-period N (spi_bitrate=N ≥2), the first SCK rise comes ≤N cycles after div_en. It can come earlier because the divider's counter is not cleared when en drops. mosi is valid ≥1 cycle before every rise.
- MISO is sampled at the clk_cpu edge one cycle after the SCK rise.
- MOSI changes at the clk_cpu edge one cycle after the SCK fall. Hold ≥1 cycle after the fall.
- Completion is one cycle after the DATA_W-th SCK fall. At that edge done=1, rx_data is valid and cs_n=1.
- Transfer length is about 2·N·DATA_W + 2 clk_cpu cycles.

## Configuration
- SPI_LSB_FIRST_EN defined: first bit is tx_data[0], tx_shift shifts right, and rx_shift inserts miso at bit DATA_W-1 and shifts right. Word bit 0 travels first on both lines.
- SPI_LSB_FIRST_EN undefined: MSB-first as described in Operation.
- Handshake and timing are identical in both builds.

## Test plan
- Loopback, DATA_W=8, spi_bitrate=2, miso=mosi, tx_data=0xA5 -> exactly 8 rises while cs_n=0, rx_data=0xA5, done high exactly 1 cycle, busy and cs_n drop on that same cycle.
- Slave model returns 0x3C MSB-first, tx_data=0xFF -> mosi=1 at every rise, rx_data=0x3C.
- start pulsed again with tx_data=0x00 mid-transfer of 0xC3 (loopback) -> ignored, rx_data=0xC3, one done pulse only.
- rst asserted after 4th rise of 0x5A -> same cycle cs_n=1, div_en=0, busy=0, rx_data=0x00. Next start 0x5A completes normally with rx_data=0x5A.
- start held high through done, loopback 0x12 then 0x34 -> second transfer starts on the done cycle, cs_n high exactly 1 cycle, rx_data=0x12 then 0x34.
- SPI_LSB_FIRST_EN defined, tx_data=0x01, loopback -> mosi=1 at first rise and 0 at rises 2–8, rx_data=0x01.

Source files
------------

// File: rtl/spi_master_shifter_if.sv
// Bus between the CPU-side SPI registers / clock divider and the mode-0 shift engine.
// The shifter connects through the slave modport; the environment uses the master modport.
interface spi_master_shifter_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              sck_in;
    logic              miso;
    logic              div_en;
    logic              cs_n;
    logic              mosi;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;

    modport slave (
        input  start, tx_data, sck_in, miso,
        output div_en, cs_n, mosi, rx_data, busy, done
    );

    modport master (
        output start, tx_data, sck_in, miso,
        input  div_en, cs_n, mosi, rx_data, busy, done
    );
endinterface

// File: rtl/spi_master_shifter.sv
// Mode-0 SPI shift engine for one word; SCK from the divider is edge-detected on clk_cpu.
// Build option SPI_LSB_FIRST_EN: word bit 0 travels first on MOSI and MISO (default MSB-first).
module spi_master_shifter #(
    parameter int DATA_W = 8
) (
    input  logic                clk_cpu,
    input  logic                rst,
    spi_master_shifter_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q,  rx_data_d;
    logic              sck_q,      sck_d;
    logic              div_en_q,   div_en_d;
    logic              cs_n_q,     cs_n_d;
    logic              mosi_q,     mosi_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    logic rise;
    logic fall;

    assign rise = bus.sck_in & ~sck_q;
    assign fall = ~bus.sck_in & sck_q;

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            sck_q      <= 1'b0;
            div_en_q   <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            sck_q      <= sck_d;
            div_en_q   <= div_en_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        sck_d      = bus.sck_in;
        div_en_d   = div_en_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                div_en_d = 1'b0;
                cs_n_d   = 1'b1;
                busy_d   = 1'b0;
                if (bus.start) begin
                    tx_shift_d = bus.tx_data;
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    cs_n_d     = 1'b0;
                    div_en_d   = 1'b1;
                    busy_d     = 1'b1;
`ifdef SPI_LSB_FIRST_EN
                    mosi_d     = bus.tx_data[0];
`else
                    mosi_d     = bus.tx_data[DATA_W-1];
`endif
                    state_d    = XFER;
                end
            end

            XFER: begin
                if (rise) begin
`ifdef SPI_LSB_FIRST_EN
                    rx_shift_d = {bus.miso, rx_shift_q[DATA_W-1:1]};
`else
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], bus.miso};
`endif
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                end else if (fall) begin
                    // The last fall closes the word; earlier falls advance MOSI.
                    if (bit_cnt_q == LAST_CNT) begin
                        div_en_d  = 1'b0;
                        cs_n_d    = 1'b1;
                        busy_d    = 1'b0;
                        rx_data_d = rx_shift_q;
                        done_d    = 1'b1;
                        mosi_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
`ifdef SPI_LSB_FIRST_EN
                        tx_shift_d = tx_shift_q >> 1;
                        mosi_d     = tx_shift_q[1];
`else
                        tx_shift_d = tx_shift_q << 1;
                        mosi_d     = tx_shift_q[DATA_W-2];
`endif
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.div_en  = div_en_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.mosi    = mosi_q;
    assign bus.rx_data = rx_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Scoreboard bench for spi_master_shifter with a behavioural clock divider and SPI slave.
module tb_spi_master_shifter;
    localparam int N = 2;

    logic clk_cpu = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_cpu = ~clk_cpu;

    spi_master_shifter_if #(.DATA_W(8)) bus ();

    spi_master_shifter #(.DATA_W(8)) dut (
        .clk_cpu (clk_cpu),
        .rst     (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   rise_cnt = 0;
    logic done_prev = 1'b0;
    logic sck_prev  = 1'b0;
    logic [7:0] mosi_seq = '0;
    exp_t e;

    // divider: toggles SCK every N enabled cycles, counter is held (not cleared) while disabled
    int div_cnt;
    always @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            div_cnt    <= 0;
            bus.sck_in <= 1'b0;
        end else if (!bus.div_en) begin
            bus.sck_in <= 1'b0;
        end else if (div_cnt == N - 1) begin
            div_cnt    <= 0;
            bus.sck_in <= ~bus.sck_in;
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end

    function automatic int bpos(int i);
`ifdef SPI_LSB_FIRST_EN
        return i;
`else
        return 7 - i;
`endif
    endfunction

    // slave: presents bit 0 of the word order on CS assertion, advances after each SCK fall
    logic       slave_mode = 1'b0;
    logic [7:0] slave_word = '0;
    int         slave_idx;
    logic       slave_sck_prev;
    logic       slave_bit;
    always @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            slave_idx      <= 0;
            slave_sck_prev <= 1'b0;
        end else begin
            slave_sck_prev <= bus.sck_in;
            if (bus.cs_n) slave_idx <= 0;
            else if (!bus.sck_in && slave_sck_prev) slave_idx <= slave_idx + 1;
        end
    end
    always_comb begin
        slave_bit = 1'b0;
        if (slave_idx < 8) slave_bit = slave_word[bpos(slave_idx)];
    end
    assign bus.miso = slave_mode ? slave_bit : bus.mosi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops one expectation per done pulse
    always @(negedge clk_cpu) begin
        if (rst) begin
            rise_cnt  = 0;
            mosi_seq  = '0;
            done_prev = 1'b0;
            sck_prev  = 1'b0;
        end else begin
            if (bus.done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got rx_data=%h expected no done", bus.rx_data);
                end else begin
                    e = sb.pop_front();
                    chk("rx_data", 32'(bus.rx_data), 32'(e.rx));
                    chk("rise_count", 32'(rise_cnt), 32'd8);
                    chk("mosi_at_rises", 32'(mosi_seq), 32'(e.tx));
                    chk("done_cycle_csn_busy_diven", {29'd0, bus.cs_n, bus.busy, bus.div_en}, 32'b100);
                    chk("done_single_cycle", 32'(done_prev), 32'd0);
                end
                rise_cnt = 0;
                mosi_seq = '0;
            end else if (bus.sck_in && !sck_prev && !bus.cs_n) begin
                if (rise_cnt < 8) mosi_seq[bpos(rise_cnt)] = bus.mosi;
                rise_cnt++;
            end
            done_prev = bus.done;
            sck_prev  = bus.sck_in;
        end
    end

    task automatic start_xfer(input logic [7:0] tx, input logic [7:0] rx);
        exp_t x;
        @(negedge clk_cpu);
        bus.start   = 1'b1;
        bus.tx_data = tx;
        x.tx = tx;
        x.rx = rx;
        sb.push_back(x);
        @(negedge clk_cpu);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_cpu);
            #1;
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done_cnt=%0d expected %0d", done_cnt, target);
        end
    endtask

    initial begin
        exp_t x;
        bit   ok;
        bus.start   = 1'b0;
        bus.tx_data = '0;
        repeat (3) @(negedge clk_cpu);
        chk("reset_outputs", {20'd0, bus.div_en, bus.cs_n, bus.mosi, bus.busy, bus.done, 7'd0},
            {20'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0});
        chk("reset_rx_data", 32'(bus.rx_data), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk_cpu);
        chk("idle_outputs", {29'd0, bus.cs_n, bus.busy, bus.div_en}, 32'b100);

        // loopback 0xA5
        start_xfer(8'hA5, 8'hA5);
        wait_done(1);

        // slave returns 0x3C while master sends 0xFF
        slave_mode = 1'b1;
        slave_word = 8'h3C;
        start_xfer(8'hFF, 8'h3C);
        wait_done(2);
        @(negedge clk_cpu);
        slave_mode = 1'b0;

        // start during a transfer is ignored
        start_xfer(8'hC3, 8'hC3);
        repeat (10) @(negedge clk_cpu);
        bus.start   = 1'b1;
        bus.tx_data = 8'h00;
        @(negedge clk_cpu);
        bus.start = 1'b0;
        wait_done(3);
        repeat (40) @(negedge clk_cpu);
        chk("ignored_start_done_count", 32'(done_cnt), 32'd3);
        chk("ignored_start_idle_busy", 32'(bus.busy), 32'd0);

        // async reset after 4th rise of 0x5A
        start_xfer(8'h5A, 8'h5A);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_cpu);
            #1;
            if (rise_cnt >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_4th_rise", 32'(ok), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midreset_outputs", {27'd0, bus.cs_n, bus.div_en, bus.busy, bus.done, bus.mosi}, 32'b10000);
        chk("midreset_rx_data", 32'(bus.rx_data), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk_cpu);
        rst = 1'b0;
        repeat (3) @(negedge clk_cpu);
        chk("post_reset_no_done", 32'(done_cnt), 32'd3);
        start_xfer(8'h5A, 8'h5A);
        wait_done(4);

        // back-to-back with start held through done
        @(negedge clk_cpu);
        bus.start   = 1'b1;
        bus.tx_data = 8'h12;
        x.tx = 8'h12;
        x.rx = 8'h12;
        sb.push_back(x);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_cpu);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("b2b_first_done", 32'(ok), 32'd1);
        bus.tx_data = 8'h34;
        x.tx = 8'h34;
        x.rx = 8'h34;
        sb.push_back(x);
        @(negedge clk_cpu);
        chk("b2b_csn_high_one_cycle", {30'd0, bus.cs_n, bus.busy}, 32'b01);
        bus.start = 1'b0;
        wait_done(6);

        // single set bit travels in the configured order
        start_xfer(8'h01, 8'h01);
        wait_done(7);

        repeat (5) @(negedge clk_cpu);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
